// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit owning the architectural HI/LO
// registers. One shift-add (multiply) or restoring shift-subtract (divide) step
// is performed per cycle, WIDTH steps per operation.
//
// Optional feature macro: MULT_DIV_SIGNED_EN
//   defined     : op[0]=1 selects signed MULT/DIV. The operands are converted to
//                 magnitudes on acceptance, and the result signs are fixed up
//                 on the final step.
//   not defined : op[0] is ignored. MULT behaves as MULTU and DIV as DIVU, and
//                 no sign-correction logic is built.
//
// Handshake: start is sampled on a rising edge and is accepted only while
// busy=0. That is the case in IDLE and in the FINISH cycle, so back-to-back
// issue is possible. Once accepted, busy is high for WIDTH cycles. Next comes
// one cycle with done=1, and in that cycle hi/lo already hold the new result.
// A start that arrives while busy=1 is dropped with no side effects. hi/lo
// change only on the edge that enters FINISH.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             last_step;
   logic [CW-1:0]    count;

   // Operation context captured at acceptance.
   logic             is_div;
   logic             b_zero;
   logic [WIDTH-1:0] dividend;   // raw rs value, returned as HI on divide by zero
   logic [WIDTH-1:0] operand;    // multiplicand magnitude or divisor magnitude

   // Working registers. For a multiply, acc is the running upper half and work
   // holds the multiplier, which shifts out as the product's low half shifts in.
   // For a divide, acc is the partial remainder and work holds the dividend,
   // which shifts out as the quotient bits shift in.
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] work;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] acc_step;
   logic [WIDTH-1:0] work_step;

   logic [2*WIDTH-1:0] prod_mag;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

`ifdef MULT_DIV_SIGNED_EN
   logic a_neg;
   logic b_neg;
   logic neg_q;   // sign of the quotient, also used as the sign of the product
   logic neg_r;   // sign of the remainder, which follows the dividend

   assign a_neg = op[0] & a[WIDTH-1];
   assign b_neg = op[0] & b[WIDTH-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   // Latch the result signs when an operation is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (accept) begin
         neg_q <= a_neg ^ b_neg;
         neg_r <= a_neg;
      end
   end
`else
   // op[0] has no meaning when every operation is unsigned.
   logic unused_op_sign;
   assign unused_op_sign = op[0];
   assign a_mag = a;
   assign b_mag = b;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. Acceptance is possible in IDLE and in FINISH, but not in RUN.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (count == CW'(1)) begin
               state_nxt = FINISH;
            end
         end
         FINISH: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy      = (state == RUN);
   assign done      = (state == FINISH);
   assign last_step = (state == RUN) && (count == CW'(1));

   // One iteration step. Multiply adds the multiplicand when the low multiplier
   // bit is set and then shifts right. Divide shifts left and subtracts, and it
   // restores the partial remainder when the subtraction borrows.
   always_comb begin
      acc_step  = acc;
      work_step = work;
      mul_sum   = {1'b0, acc} + (work[0] ? {1'b0, operand} : '0);
      div_shift = {acc, work[WIDTH-1]};
      div_diff  = div_shift - {1'b0, operand};
      if (is_div) begin
         if (!div_diff[WIDTH]) begin
            acc_step  = div_diff[WIDTH-1:0];
            work_step = {work[WIDTH-2:0], 1'b1};
         end else begin
            acc_step  = div_shift[WIDTH-1:0];
            work_step = {work[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_step  = mul_sum[WIDTH:1];
         work_step = {mul_sum[0], work[WIDTH-1:1]};
      end
   end

   // Final result, formed from the last step's values. Divide by zero
   // overrides the iterative result, so it behaves the same for signed and
   // unsigned divides.
   always_comb begin
      prod_mag = {acc_step, work_step};
      prod     = prod_mag;
      res_hi   = acc_step;
      res_lo   = work_step;
`ifdef MULT_DIV_SIGNED_EN
      if (neg_q) begin
         prod = -prod_mag;
      end
`endif
      if (!is_div) begin
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end else if (b_zero) begin
         res_hi = dividend;
         res_lo = '1;
      end else begin
`ifdef MULT_DIV_SIGNED_EN
         if (neg_q) begin
            res_lo = -work_step;
         end
         if (neg_r) begin
            res_hi = -acc_step;
         end
`endif
      end
   end

   // Datapath: capture operands on acceptance, iterate while running, and
   // update HI/LO only on the edge that enters FINISH.
   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= '0;
         is_div   <= 1'b0;
         b_zero   <= 1'b0;
         dividend <= '0;
         operand  <= '0;
         acc      <= '0;
         work     <= '0;
         hi       <= '0;
         lo       <= '0;
      end else if (accept) begin
         count    <= CW'(WIDTH);
         is_div   <= op[1];
         b_zero   <= (b == '0);
         dividend <= a;
         operand  <= op[1] ? b_mag : a_mag;
         acc      <= '0;
         work     <= op[1] ? a_mag : b_mag;
      end else if (state == RUN) begin
         count <= count - CW'(1);
         acc   <= acc_step;
         work  <= work_step;
         if (last_step) begin
            hi <= res_hi;
            lo <= res_lo;
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit. The behavioural reference model uses plain
// 64-bit arithmetic. Signed results are modelled only when MULT_DIV_SIGNED_EN
// is defined, to match the build of the unit.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int vectors     = 0;
  int miscompares = 0;

  logic [2*W-1:0] exp_q[$];

  // Directed cases: MULTU, MULT, DIV, DIVU, DIVU by zero, DIV by zero, and DIV overflow.
  localparam int N_DIR = 7;
  logic [1:0]   t_op[N_DIR] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd3, 2'd3};
  logic [W-1:0] t_a[N_DIR]  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100,
                                32'h12345678, 32'hFFFFFFF0, 32'h80000000};
  logic [W-1:0] t_b[N_DIR]  = '{32'h00000002, 32'h00000007, 32'h00000002, 32'd7,
                                32'h00000000, 32'h00000000, 32'hFFFFFFFF};

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    logic     sgn;
    longint   sx;
    longint   sy;
    longint   q;
    longint   r;
    logic [63:0] p;
    sgn = 1'b0;
`ifdef MULT_DIV_SIGNED_EN
    sgn = o[0];
`endif
    sx = $signed(x);
    sy = $signed(y);
    if (!o[1]) begin
      if (sgn) p = sx * sy;
      else     p = {32'b0, x} * {32'b0, y};
      return p;
    end
    if (y == '0) return {x, 32'hFFFFFFFF};
    if (sgn) begin
      q = sx / sy;
      r = sx % sy;
      return {r[31:0], q[31:0]};
    end
    return {x % y, x / y};
  endfunction

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 7))
      0:       return 32'h00000000;
      1:       return 32'($urandom_range(1, 15));
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge. It holds start for one rising edge, then scrambles
  // the operands so that a late capture would show up in the result.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    exp_q.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom_range(0, 3));
    a     = $urandom;
    b     = $urandom;
  endtask

  // Waits, for a bounded number of cycles, until done is seen. lat counts the
  // cycles after acceptance. It also records whether busy stayed high and
  // whether hi/lo held their old values during the run. If inject_at is
  // nonzero, one extra start pulse is driven in that cycle of the run.
  task automatic wait_done(input logic [W-1:0] ph, input logic [W-1:0] pl, input int inject_at,
                           output int lat, output bit busy_ok, output bit hold_ok);
    lat     = 1;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (done !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (hi !== ph || lo !== pl) hold_ok = 1'b0;
      if (lat == inject_at) begin
        start = 1'b1;
        op    = 2'($urandom_range(0, 3));
        a     = $urandom;
        b     = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;   // start together with reset must be dropped
    op = 2'd0; a = 32'd5; b = 32'd6;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({busy, done, hi, lo} !== '0) begin
        miscompares++;
        $display("FAIL reset_idle cyc%0d: busy=%b done=%b hi=%h lo=%h, want all zero",
                 i, busy, done, hi, lo);
      end
    end
  endtask

  task automatic test_directed();
    int lat; bit busy_ok; bit hold_ok; logic [W-1:0] ph; logic [W-1:0] pl; logic [2*W-1:0] exp;
    for (int i = 0; i < N_DIR; i++) begin
      ph = hi; pl = lo;
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done(ph, pl, 0, lat, busy_ok, hold_ok);
      exp = exp_q.pop_front();
      vectors++;
      if (lat != 33) begin
        miscompares++;
        $display("FAIL directed%0d latency: got %0d, want 33", i, lat);
      end
      vectors++;
      if (!busy_ok || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL directed%0d busy: run_ok=%b busy_at_done=%b, want 1/0", i, busy_ok, busy);
      end
      vectors++;
      if (!hold_ok) begin
        miscompares++;
        $display("FAIL directed%0d hold: hi/lo changed during run, want %h/%h", i, ph, pl);
      end
      vectors++;
      if ({hi, lo} !== exp) begin
        miscompares++;
        $display("FAIL directed%0d result op=%0d a=%h b=%h: got hi=%h lo=%h, want hi=%h lo=%h",
                 i, t_op[i], t_a[i], t_b[i], hi, lo, exp[63:32], exp[31:0]);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL directed%0d pulse: done=%b busy=%b after done cycle, want 0/0", i, done, busy);
      end
    end
  endtask

  task automatic test_random();
    int lat; int inj; bit busy_ok; bit hold_ok;
    logic [W-1:0] ph; logic [W-1:0] pl; logic [W-1:0] x; logic [W-1:0] y;
    logic [1:0] o; logic [2*W-1:0] exp;
    for (int i = 0; i < 40; i++) begin
      o   = 2'($urandom_range(0, 3));
      x   = rand_val();
      y   = rand_val();
      inj = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : 0;
      ph = hi; pl = lo;
      issue(o, x, y);
      wait_done(ph, pl, inj, lat, busy_ok, hold_ok);
      exp = exp_q.pop_front();
      vectors++;
      if (lat != 33 || !busy_ok || !hold_ok) begin
        miscompares++;
        $display("FAIL random%0d timing: lat=%0d busy_ok=%b hold_ok=%b, want 33/1/1",
                 i, lat, busy_ok, hold_ok);
      end
      vectors++;
      if ({hi, lo} !== exp) begin
        miscompares++;
        $display("FAIL random%0d result op=%0d a=%h b=%h: got hi=%h lo=%h, want hi=%h lo=%h",
                 i, o, x, y, hi, lo, exp[63:32], exp[31:0]);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_busy_ignore();
    int lat; int extra; bit busy_ok; bit hold_ok;
    logic [W-1:0] ph; logic [W-1:0] pl; logic [2*W-1:0] exp;
    @(negedge clk);
    ph = hi; pl = lo;
    issue(2'd2, 32'h12345678, 32'h0);
    wait_done(ph, pl, 10, lat, busy_ok, hold_ok);
    exp = exp_q.pop_front();
    vectors++;
    if (lat != 33 || !busy_ok || !hold_ok) begin
      miscompares++;
      $display("FAIL busy_ignore timing: lat=%0d busy_ok=%b hold_ok=%b, want 33/1/1",
               lat, busy_ok, hold_ok);
    end
    vectors++;
    if ({hi, lo} !== exp) begin
      miscompares++;
      $display("FAIL busy_ignore result: got hi=%h lo=%h, want hi=%h lo=%h",
               hi, lo, exp[63:32], exp[31:0]);
    end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL busy_ignore extra_done: got %0d extra pulses, want 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    issue(2'd0, 32'd5, 32'd6);   // now in cycle N+1
    repeat (9) @(negedge clk);   // cycle N+10
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    vectors++;
    if ({busy, done, hi, lo} !== '0) begin
      miscompares++;
      $display("FAIL reset_abort state: busy=%b done=%b hi=%h lo=%h, want all zero",
               busy, done, hi, lo);
    end
    dones = 0;
    repeat (50) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0 || busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      miscompares++;
      $display("FAIL reset_abort after: dones=%0d busy=%b hi=%h lo=%h, want 0/0/0/0",
               dones, busy, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit busy_ok; bit hold_ok;
    logic [W-1:0] ph; logic [W-1:0] pl; logic [2*W-1:0] exp;
    ph = hi; pl = lo;
    issue(2'($urandom_range(0, 3)), rand_val(), rand_val());
    for (int k = 0; k < 4; k++) begin
      wait_done(ph, pl, 0, lat, busy_ok, hold_ok);
      exp = exp_q.pop_front();
      vectors++;
      if (lat != 33 || !busy_ok || !hold_ok) begin
        miscompares++;
        $display("FAIL b2b%0d timing: lat=%0d busy_ok=%b hold_ok=%b, want 33/1/1",
                 k, lat, busy_ok, hold_ok);
      end
      vectors++;
      if ({hi, lo} !== exp) begin
        miscompares++;
        $display("FAIL b2b%0d result: got hi=%h lo=%h, want hi=%h lo=%h",
                 k, hi, lo, exp[63:32], exp[31:0]);
      end
      ph = hi; pl = lo;
      if (k < 3) issue(2'($urandom_range(0, 3)), rand_val(), rand_val());
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b end: done=%b busy=%b, want 0/0", done, busy);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 2'd0;
    a     = '0;
    b     = '0;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit that consumes the two register-file read operands (RD1 -> a, RD2 -> b) and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU over 32 cycles. Signals completion so the control path can stall MFHI/MFLO until results are valid.
- Sits directly downstream of the register file, in parallel with the ALU.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request to begin an operation; sampled on rising edge
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  input  WIDTH  operand rs (multiplicand / dividend), from RD1
- b  input  WIDTH  operand rt (multiplier / divisor), from RD2
- busy  output  1  operation in progress; start is ignored while high
- done  output  1  one-cycle pulse; HI/LO were updated at this edge
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high. There is no asynchronous path.
- Reset value of every output: busy=0, done=0, hi=0, lo=0. Reset also clears the internal counter and working registers.
- States: IDLE, RUN, FINISH.
  - IDLE: if start=1, latch a, b and op; load counter with WIDTH; go to RUN. busy=1 from the next cycle.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Decrement counter each step. When counter reaches 1, go to FINISH.
  - FINISH: write results to hi/lo; done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency: start accepted at edge N; busy high in cycles N+1..N+32; done high and hi/lo valid in cycle N+33.
- Back-to-back: start asserted during the FINISH cycle (done=1, busy=0) is accepted. The new operation uses a/b present in that cycle.
- Operand capture: start while busy=1 is ignored with no side effects. a/b/op changes after acceptance have no effect.
- HI/LO update rule: hi/lo change only at the FINISH edge. They hold their previous values throughout RUN, so intermediate values are never visible.
- Multiply: {hi,lo} = a*b as a 2*WIDTH-bit product.
  - MULT uses a two's-complement signed product.
  - MULTU uses an unsigned product.
- Divide: lo = quotient, hi = remainder.
  - DIVU uses unsigned division.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
  - Signed implementation: divide the magnitudes, then fix up the signs during FINISH.
- Divide by zero (b=0): completes in the normal 33 cycles, with hi=a and lo=all ones. This applies to both DIV and DIVU.
- Signed overflow (DIV, a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0.
- Reset mid-operation: the operation is aborted, outputs take their reset values, and the unit returns to IDLE. No done pulse is produced.
- reset and start asserted in the same cycle: reset wins and start is dropped.

Optional Feature:
- Macro: MULT_DIV_SIGNED_EN.
- Defined: behaviour is exactly as described above; op[0]=1 selects signed operation.
- Not defined: op[0] is ignored, so MULT behaves as MULTU and DIV as DIVU. The sign-correction logic is not synthesized. Latency and all other behaviour are unchanged.

Test Plan:
- Reset then idle, no start -> busy=0, done=0, hi=0, lo=0 for 10 cycles.
- MULTU, a=0xFFFFFFFF, b=0x00000002, start at edge N -> done=1 only in cycle N+33; hi=0x00000001, lo=0xFFFFFFFE; busy=1 in cycles N+1..N+32.
- MULT (macro defined), a=0xFFFFFFFD (-3), b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Same stimulus with the macro undefined -> hi=0x00000006, lo=0xFFFFFFEB.
- DIV (macro defined), a=0xFFFFFFF9 (-7), b=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, a=100, b=7 -> lo=14, hi=2.
- DIVU, a=0x12345678, b=0 -> after 33 cycles hi=0x12345678, lo=0xFFFFFFFF. A start pulse injected while busy -> ignored, and exactly one done pulse is seen.
- Start MULTU 5*6, assert reset at cycle N+10 -> busy=0, hi=lo=0, no done pulse. Then a back-to-back test: second start during the done cycle -> second done pulse exactly 33 cycles later.
